// File: rtl/divider_pkg.sv
// Shared types and constants for the clock-divider strobe family.
// Holds the monitor state encoding, default sizing and the timeout derivation.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } monState_e;

  localparam int DIV_EXPECTED = 500;
  localparam int DIV_CNT_W    = 10;

  // A period longer than the largest acceptable one means the tick has stopped.
  function automatic int timeoutCycles(input int expected, input int tol);
    return expected + tol + 1;
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Turns the incoming tick strobe into a single-cycle event on its rising edge.
// Optional feature macro: TICK_PERIOD_SYNC_EN adds a 2-flop synchroniser in
// front of the edge detector so the tick may come from an unrelated domain.
module tick_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic tick_i,
  output logic event_o
);

  logic tickSrc;
  logic tickDly_q;

`ifdef TICK_PERIOD_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-stage resynchronisation of the asynchronous tick into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= tick_i;
      sync2_q <= sync1_q;
    end
  end

  assign tickSrc = sync2_q;
`else
  assign tickSrc = tick_i;
`endif

  // Delayed copy of the tick so a long-held strobe yields only one event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tickDly_q <= 1'b0;
    end else begin
      tickDly_q <= tickSrc;
    end
  end

  assign event_o = tickSrc & ~tickDly_q;

endmodule

// File: rtl/tick_period_monitor.sv
// Run-time health monitor for a periodic tick: measures the cycle count
// between tick events, flags out-of-tolerance periods, missing ticks and
// reports lock after a run of good periods.
// Optional feature macro: TICK_PERIOD_SYNC_EN (synchroniser in tick_edge_detect).
module tick_period_monitor
  import divider_pkg::*;
#(
  parameter int W          = DIV_CNT_W,
  parameter int EXPECTED   = DIV_EXPECTED,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick_in,
  output logic [W-1:0] period_out,
  output logic         period_valid,
  output logic         period_err,
  output logic         timeout_err,
  output logic         locked
);

  localparam logic [W-1:0] PERIOD_LO   = W'(EXPECTED - TOL);
  localparam logic [W-1:0] PERIOD_HI   = W'(EXPECTED + TOL);
  localparam logic [W-1:0] TIMEOUT_CNT = W'(timeoutCycles(EXPECTED, TOL));
  localparam logic [W-1:0] CNT_ONE     = W'(1);
  localparam logic [3:0]   LOCK_N      = 4'(LOCK_COUNT);

  monState_e    state_q;
  logic [W-1:0] cnt_q;
  logic [3:0]   goodCnt_q;
  logic [W-1:0] periodOut_q;
  logic         periodValid_q;
  logic         periodErr_q;
  logic         timeoutErr_q;
  logic         locked_q;

  logic         tickEvent;
  logic [W-1:0] cntInc_d;
  logic [3:0]   goodInc_d;
  logic         periodGood;

  tick_edge_detect u_edge (
    .clock   (clock),
    .reset   (reset),
    .tick_i  (tick_in),
    .event_o (tickEvent)
  );

  assign cntInc_d   = cnt_q + CNT_ONE;
  assign goodInc_d  = goodCnt_q + 4'd1;
  assign periodGood = (cnt_q >= PERIOD_LO) && (cnt_q <= PERIOD_HI);

  // Measurement FSM: counts cycles between events, grades each period and
  // tracks lock; an event in the timeout cycle is still reported as a period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      goodCnt_q     <= '0;
      periodOut_q   <= '0;
      periodValid_q <= 1'b0;
      periodErr_q   <= 1'b0;
      timeoutErr_q  <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      periodValid_q <= 1'b0;
      periodErr_q   <= 1'b0;
      timeoutErr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tickEvent) begin
            state_q <= MEASURE;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        MEASURE, LOCKED: begin
          if (tickEvent) begin
            cnt_q         <= CNT_ONE;
            periodOut_q   <= cnt_q;
            periodValid_q <= 1'b1;
            if (periodGood) begin
              if (state_q == MEASURE) begin
                goodCnt_q <= goodInc_d;
                if (goodInc_d >= LOCK_N) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end
            end else begin
              periodErr_q <= 1'b1;
              goodCnt_q   <= '0;
              locked_q    <= 1'b0;
              state_q     <= MEASURE;
            end
          end else if (cnt_q == TIMEOUT_CNT) begin
            timeoutErr_q <= 1'b1;
            locked_q     <= 1'b0;
            goodCnt_q    <= '0;
            cnt_q        <= '0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cntInc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign period_out   = periodOut_q;
  assign period_valid = periodValid_q;
  assign period_err   = periodErr_q;
  assign timeout_err  = timeoutErr_q;
  assign locked       = locked_q;

endmodule
